// File: rtl/adder_pkg.sv
// Shared definitions for the adder4bit-based datapaths: nibble width and the
// sequencing FSM state encoding.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder. With SIGNED_OVF_EN defined
// the signed-overflow flag ovf is part of the bundle.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    import adder_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SIGNED_OVF_EN
    logic         ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/adder4bit.sv
// Combinational 4-bit adder with carry in/out; the one shared adder slice.
module adder4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in1,
    input  logic [NIBBLE_W-1:0] in2,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] out,
    output logic                carry
);

    logic [NIBBLE_W:0] full;

    assign full  = {1'b0, in1} + {1'b0, in2} + {{NIBBLE_W{1'b0}}, cin};
    assign out   = full[NIBBLE_W-1:0];
    assign carry = full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two NIBBLES*4-bit operands one nibble per cycle through one adder4bit.
// Optional feature macro: SIGNED_OVF_EN (adds the signed-overflow flag ovf).
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    nibble_serial_adder_if.slave   bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       s_sh;
    logic               c_reg;
    logic [IDX_W-1:0]   idx;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_c;
    logic [W-1:0]       s_next;
`ifdef SIGNED_OVF_EN
    logic               a_msb;
    logic               b_msb;
`endif

    adder4bit u_adder4bit (
        .in1   (a_sh[NIBBLE_W-1:0]),
        .in2   (b_sh[NIBBLE_W-1:0]),
        .cin   (c_reg),
        .out   (nib_sum),
        .carry (nib_c)
    );

    // Result nibbles enter at the top so nibble 0 lands at the bottom after the last step.
    assign s_next = {nib_sum, s_sh[W-1:NIBBLE_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c_reg    <= 1'b0;
            idx      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
`ifdef SIGNED_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            bus.ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        c_reg    <= bus.cin;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
`ifdef SIGNED_OVF_EN
                        a_msb    <= bus.a[W-1];
                        b_msb    <= bus.b[W-1];
`endif
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    s_sh  <= s_next;
                    c_reg <= nib_c;
                    if (idx == LAST) begin
                        idx      <= '0;
                        bus.sum  <= s_next;
                        bus.cout <= nib_c;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
`ifdef SIGNED_OVF_EN
                        bus.ovf  <= (a_msb == b_msb) && (nib_sum[NIBBLE_W-1] != a_msb);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: stimulus pushes expected results
// computed with plain integer arithmetic; a monitor pops them on every done.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   st_cyc;
    int   done_cnt;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t   e;
        longint ua, ub, full, sa, sb_, r, lim;
        ua   = longint'(a);
        ub   = longint'(b);
        full = ua + ub + longint'(cin);
        e.sum  = W'(full % (longint'(1) << W));
        e.cout = (full >= (longint'(1) << W));
        lim  = longint'(1) << (W - 1);
        sa   = (ua >= lim) ? ua - (longint'(1) << W) : ua;
        sb_  = (ub >= lim) ? ub - (longint'(1) << W) : ub;
        r    = sa + sb_ + longint'(cin);
        e.ovf  = (r >= lim) || (r < -lim);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 64'(bus.sum), 64'(e.sum));
                chk("cout", 64'(bus.cout), 64'(e.cout));
`ifdef SIGNED_OVF_EN
                chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
            end
        end
    end

    // Drive a request so it is sampled on the next edge; returns just after that edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input bit expect_result);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        if (expect_result) sb.push_back(model(a, b, cin));
        @(posedge clk);
        #1;
        st_cyc    = cyc;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        bit ok;
        ok     = 0;
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                ok  = 1;
                lat = cyc - st_cyc;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, busy_n, d1, d2, saved;
        logic [W-1:0] ra, rb;
        n_checks  = 0;
        n_pass    = 0;
        done_cnt  = 0;
        st_cyc    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef SIGNED_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        @(posedge clk); #1;

        // Wrap-around with carry out
        issue(16'hFFFF, 16'h0001, 1'b0, 1);
        wait_done(lat, busy_n);
        chk("t1_latency", 64'(lat), 64'(NIB));
        chk("t1_sum", 64'(bus.sum), 64'h0000);
        chk("t1_cout", 64'(bus.cout), 64'd1);
        @(posedge clk); #1;

        issue(16'h1234, 16'h4321, 1'b1, 1);
        wait_done(lat, busy_n);
        chk("t2_busy_cycles", 64'(busy_n), 64'(NIB));
        chk("t2_sum", 64'(bus.sum), 64'h5556);
        @(posedge clk); #1;

        // Start pulsed during RUN must be ignored
        saved = done_cnt;
        issue(16'h00CF, 16'h000F, 1'b0, 1);
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.cin   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, busy_n);
        chk("t3_latency", 64'(lat), 64'(NIB));
        chk("t3_sum", 64'(bus.sum), 64'h00DE);
        repeat (8) @(posedge clk);
        #1;
        chk("t3_single_done", 64'(done_cnt - saved), 64'd1);

        // Reset in the second RUN cycle aborts with no done
        saved = done_cnt;
        issue(16'h2222, 16'h3333, 1'b0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        chk("t4_sum", 64'(bus.sum), 64'd0);
        chk("t4_cout", 64'(bus.cout), 64'd0);
        repeat (8) @(negedge clk);
        chk("t4_no_done", 64'(done_cnt - saved), 64'd0);
        @(posedge clk); #1;
        issue(16'hABCD, 16'h1111, 1'b1, 1);
        wait_done(lat, busy_n);
        chk("t4_next_sum", 64'(bus.sum), 64'hBCDF);
        @(posedge clk); #1;

        // Back-to-back issue with start held in DONE
        issue(16'h0100, 16'h0200, 1'b0, 1);
        wait_done(lat, busy_n);
        d1 = cyc;
        bus.start = 1'b1;
        bus.a     = 16'h0008;
        bus.b     = 16'h0003;
        bus.cin   = 1'b0;
        sb.push_back(model(16'h0008, 16'h0003, 1'b0));
        @(posedge clk); #1;
        st_cyc    = cyc;
        bus.start = 1'b0;
        wait_done(lat, busy_n);
        d2 = cyc;
        chk("t5_spacing", 64'(d2 - d1), 64'(NIB + 1));
        chk("t5_sum", 64'(bus.sum), 64'h000B);
        @(posedge clk); #1;

        // Signed-overflow boundaries (sum/cout checked in every build)
        issue(16'h7FFF, 16'h0001, 1'b0, 1);
        wait_done(lat, busy_n);
        chk("t6_sum", 64'(bus.sum), 64'h8000);
`ifdef SIGNED_OVF_EN
        chk("t6_ovf_pos", 64'(bus.ovf), 64'd1);
`endif
        @(posedge clk); #1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1);
        wait_done(lat, busy_n);
        chk("t6_cout", 64'(bus.cout), 64'd1);
`ifdef SIGNED_OVF_EN
        chk("t6_ovf_none", 64'(bus.ovf), 64'd0);
`endif
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            issue(ra, rb, 1'($urandom), 1);
            wait_done(lat, busy_n);
            chk("rand_latency", 64'(lat), 64'(NIB));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
